// File: rtl/hart_run_ctl.sv
// hart_run_ctl: independent run/halt/resume controllers, one per hart, for a debug module.
// Single-step support is compiled in only when HART_RUN_CTL_STEP_EN is defined.
module hart_run_ctl #(
  parameter int NHARTS       = 1,
  parameter int HALT_TIMEOUT = 255,
  parameter int RESET_HALT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NHARTS-1:0]     halt_req,
  input  logic [NHARTS-1:0]     resume_req,
  input  logic [NHARTS-1:0]     core_halted,
  input  logic [NHARTS-1:0]     core_retire,
  input  logic [NHARTS-1:0]     step,
  output logic [NHARTS-1:0]     debug,
  output logic [NHARTS-1:0]     halted,
  output logic [NHARTS-1:0]     resume_ack,
  output logic [3*NHARTS-1:0]   halt_cause,
  output logic [NHARTS-1:0]     halt_err,
  output logic                  any_halted,
  output logic                  all_halted
);

  typedef enum logic [1:0] {
    RUNNING  = 2'd0,
    HALTING  = 2'd1,
    HALTED   = 2'd2,
    RESUMING = 2'd3
  } state_t;

  localparam logic [2:0]  CAUSE_NONE    = 3'd0;
  localparam logic [2:0]  CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0]  CAUSE_STEP    = 3'd4;
  localparam logic [2:0]  CAUSE_RESET   = 3'd5;
  localparam logic [15:0] TIMEOUT       = 16'(HALT_TIMEOUT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      return val;
    end else begin
      return val + 16'd1;
    end
  endfunction

`ifndef HART_RUN_CTL_STEP_EN
  logic unused_step_inputs;
  assign unused_step_inputs = ^{step, core_retire};
`endif

  for (genvar i = 0; i < NHARTS; i++) begin : g_hart
    state_t      state_r;
    logic [15:0] cnt_r;
    logic [2:0]  cause_r;
    logic        debug_r;
    logic        halted_r;
    logic        ack_r;
    logic        err_r;
    logic        req_q_r;
`ifdef HART_RUN_CTL_STEP_EN
    logic        step_armed_r;
`endif

    // Per-hart FSM; all outputs are registered from the same transition decisions.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r  <= (RESET_HALT != 0) ? HALTING : RUNNING;
        cnt_r    <= 16'd0;
        cause_r  <= (RESET_HALT != 0) ? CAUSE_RESET : CAUSE_NONE;
        debug_r  <= (RESET_HALT != 0);
        halted_r <= 1'b0;
        ack_r    <= 1'b0;
        err_r    <= 1'b0;
        req_q_r  <= 1'b0;
`ifdef HART_RUN_CTL_STEP_EN
        step_armed_r <= 1'b0;
`endif
      end else begin
        req_q_r <= halt_req[i];
        ack_r   <= 1'b0;
        case (state_r)
          RUNNING: begin
            if (halt_req[i]) begin
              state_r <= HALTING;
              cause_r <= CAUSE_HALTREQ;
              debug_r <= 1'b1;
              cnt_r   <= 16'd0;
              if (!req_q_r) begin
                err_r <= 1'b0;
              end else begin
                err_r <= err_r;
              end
`ifdef HART_RUN_CTL_STEP_EN
              step_armed_r <= 1'b0;
            end else if (step_armed_r && core_retire[i]) begin
              state_r      <= HALTING;
              cause_r      <= CAUSE_STEP;
              debug_r      <= 1'b1;
              cnt_r        <= 16'd0;
              step_armed_r <= 1'b0;
`endif
            end else begin
              state_r <= RUNNING;
            end
          end
          HALTING: begin
            // The error flag rises on the edge that completes the HALT_TIMEOUT-th HALTING cycle.
            cnt_r <= sat_inc16(cnt_r);
            if (sat_inc16(cnt_r) == TIMEOUT) begin
              err_r <= 1'b1;
            end else begin
              err_r <= err_r;
            end
            if (core_halted[i]) begin
              state_r  <= HALTED;
              halted_r <= 1'b1;
            end else begin
              state_r <= HALTING;
            end
          end
          HALTED: begin
            if (resume_req[i] && !halt_req[i]) begin
              state_r  <= RESUMING;
              debug_r  <= 1'b0;
              halted_r <= 1'b0;
            end else begin
              state_r <= HALTED;
            end
          end
          RESUMING: begin
            if (!core_halted[i]) begin
              state_r <= RUNNING;
              ack_r   <= 1'b1;
`ifdef HART_RUN_CTL_STEP_EN
              step_armed_r <= step[i];
`endif
            end else begin
              state_r <= RESUMING;
            end
          end
          default: begin
            state_r  <= RUNNING;
            debug_r  <= 1'b0;
            halted_r <= 1'b0;
          end
        endcase
      end
    end

    assign debug[i]              = debug_r;
    assign halted[i]             = halted_r;
    assign resume_ack[i]         = ack_r;
    assign halt_err[i]           = err_r;
    assign halt_cause[3*i +: 3]  = cause_r;
  end

  assign any_halted = |halted;
  assign all_halted = &halted;

endmodule

// File: tb/tb_hart_run_ctl.sv
// Directed, table-driven bench for hart_run_ctl with two instances:
// a normal two-hart build (HALT_TIMEOUT=8) and a RESET_HALT build.
module tb_hart_run_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [1:0] halt_a, resume_a, retire_a, step_a, mask_a, ch_a;
  logic [1:0] debug_a, halted_a, ack_a, err_a;
  logic [5:0] cause_a;
  logic       any_a, all_a;
  logic [1:0] halt_b, resume_b, mask_b, ch_b;
  logic [1:0] debug_b, halted_b, ack_b, err_b;
  logic [5:0] cause_b;
  logic       any_b, all_b;

  assign ch_a = debug_a & mask_a;
  assign ch_b = debug_b & mask_b;

  hart_run_ctl #(.NHARTS(2), .HALT_TIMEOUT(8), .RESET_HALT(0)) dut_a (
    .clk(clk), .rst(rst_a), .halt_req(halt_a), .resume_req(resume_a),
    .core_halted(ch_a), .core_retire(retire_a), .step(step_a),
    .debug(debug_a), .halted(halted_a), .resume_ack(ack_a), .halt_cause(cause_a),
    .halt_err(err_a), .any_halted(any_a), .all_halted(all_a)
  );

  hart_run_ctl #(.NHARTS(2), .HALT_TIMEOUT(255), .RESET_HALT(1)) dut_b (
    .clk(clk), .rst(rst_b), .halt_req(halt_b), .resume_req(resume_b),
    .core_halted(ch_b), .core_retire(2'b00), .step(2'b00),
    .debug(debug_b), .halted(halted_b), .resume_ack(ack_b), .halt_cause(cause_b),
    .halt_err(err_b), .any_halted(any_b), .all_halted(all_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       rst;
    logic [1:0] halt;
    logic [1:0] resume;
    logic [1:0] debug;
    logic [1:0] halted;
    logic [1:0] ack;
    logic [1:0] err;
    logic [5:0] cause;
    logic       any;
    logic       all;
  } vec_t;

  vec_t vecs [20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [1:0] dbg, input logic [1:0] hlt,
                         input logic [1:0] ack, input logic [1:0] err, input logic [5:0] cause);
    chk({tag, " debug"},  {6'd0, debug_a},  {6'd0, dbg});
    chk({tag, " halted"}, {6'd0, halted_a}, {6'd0, hlt});
    chk({tag, " ack"},    {6'd0, ack_a},    {6'd0, ack});
    chk({tag, " err"},    {6'd0, err_a},    {6'd0, err});
    chk({tag, " cause"},  {2'd0, cause_a},  {2'd0, cause});
  endtask

  task automatic check_b(input string tag, input logic [1:0] dbg, input logic [1:0] hlt,
                         input logic [1:0] ack, input logic all);
    chk({tag, " debug"},  {6'd0, debug_b},  {6'd0, dbg});
    chk({tag, " halted"}, {6'd0, halted_b}, {6'd0, hlt});
    chk({tag, " ack"},    {6'd0, ack_b},    {6'd0, ack});
    chk({tag, " all"},    {7'd0, all_b},    {7'd0, all});
    chk({tag, " err"},    {6'd0, err_b},    8'd0);
    chk({tag, " cause"},  {2'd0, cause_b},  8'h2D);
  endtask

  initial begin
    //           rst   halt   res    debug  halted ack    err    cause      any   all
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 6'b000011, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 6'b000011, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 6'b000011, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 6'b000011, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 6'b000011, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 6'b000011, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000011, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 6'b000011, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000011, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 6'b011011, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 6'b011011, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 6'b011011, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 6'b011011, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 6'b011011, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 6'b011011, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 6'b011011, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 6'b011011, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 1'b0, 1'b0};

    rst_a = 1'b1; halt_a = 2'b00; resume_a = 2'b00; retire_a = 2'b00; step_a = 2'b00; mask_a = 2'b11;
    rst_b = 1'b1; halt_b = 2'b00; resume_b = 2'b00; mask_b = 2'b00;
    tick();
    tick();

    // RESET_HALT instance: reset state, then halt completes once the core parks.
    check_b("rh reset", 2'b11, 2'b00, 2'b00, 1'b0);
    rst_b = 1'b0;
    tick();
    check_b("rh wait", 2'b11, 2'b00, 2'b00, 1'b0);
    mask_b = 2'b11;
    tick();
    check_b("rh halted", 2'b11, 2'b11, 2'b00, 1'b1);
    chk("rh any", {7'd0, any_b}, 8'd1);
    resume_b = 2'b11;
    tick();
    resume_b = 2'b00;
    check_b("rh resuming", 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    check_b("rh ack", 2'b00, 2'b00, 2'b11, 1'b0);
    tick();
    check_b("rh ack once", 2'b00, 2'b00, 2'b00, 1'b0);

    // Table-driven main function on instance A.
    for (int k = 0; k < 20; k++) begin
      rst_a    = vecs[k].rst;
      halt_a   = vecs[k].halt;
      resume_a = vecs[k].resume;
      tick();
      check_a($sformatf("vec%0d", k), vecs[k].debug, vecs[k].halted, vecs[k].ack,
              vecs[k].err, vecs[k].cause);
      chk($sformatf("vec%0d any", k), {7'd0, any_a}, {7'd0, vecs[k].any});
      chk($sformatf("vec%0d all", k), {7'd0, all_a}, {7'd0, vecs[k].all});
    end

    // Reset while hart 0 is in RESUMING suppresses the resume pulse.
    halt_a = 2'b01; tick();
    halt_a = 2'b00; tick();
    resume_a = 2'b01; tick();
    check_a("rstres resuming", 2'b00, 2'b00, 2'b00, 2'b00, 6'b000011);
    rst_a = 1'b1; resume_a = 2'b00; tick();
    check_a("rstres reset", 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000);
    rst_a = 1'b0; tick();
    check_a("rstres after", 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000);
    halt_a = 2'b01; tick();
    check_a("rstres running", 2'b01, 2'b00, 2'b00, 2'b00, 6'b000011);
    halt_a = 2'b00; tick();
    resume_a = 2'b01; tick();
    resume_a = 2'b00; tick();
    check_a("rstres back", 2'b00, 2'b00, 2'b01, 2'b00, 6'b000011);

    // Halt timeout on hart 1 with the core refusing to park.
    mask_a = 2'b01;
    halt_a = 2'b10; tick();
    for (int j = 1; j < 8; j++) tick();
    check_a("tmo before", 2'b10, 2'b00, 2'b00, 2'b00, 6'b011011);
    tick();
    check_a("tmo set", 2'b10, 2'b00, 2'b00, 2'b10, 6'b011011);
    halt_a = 2'b00;
    for (int j = 0; j < 3; j++) tick();
    check_a("tmo stay", 2'b10, 2'b00, 2'b00, 2'b10, 6'b011011);
    mask_a = 2'b11; tick();
    check_a("tmo parked", 2'b10, 2'b10, 2'b00, 2'b10, 6'b011011);
    resume_a = 2'b10; tick();
    resume_a = 2'b00; tick();
    check_a("tmo resumed", 2'b00, 2'b00, 2'b10, 2'b10, 6'b011011);
    halt_a = 2'b10; tick();
    check_a("tmo clear", 2'b10, 2'b00, 2'b00, 2'b00, 6'b011011);
    halt_a = 2'b00; tick();
    resume_a = 2'b10; tick();
    resume_a = 2'b00; tick();
    check_a("tmo run", 2'b00, 2'b00, 2'b10, 2'b00, 6'b011011);

`ifdef HART_RUN_CTL_STEP_EN
    // Single step: resume with step set, one retire re-halts with cause 4.
    halt_a = 2'b01; tick();
    halt_a = 2'b00; tick();
    step_a = 2'b01; resume_a = 2'b01; tick();
    resume_a = 2'b00; tick();
    check_a("step resumed", 2'b00, 2'b00, 2'b01, 2'b00, 6'b011011);
    tick();
    check_a("step idle", 2'b00, 2'b00, 2'b00, 2'b00, 6'b011011);
    retire_a = 2'b01; tick();
    retire_a = 2'b00;
    check_a("step halting", 2'b01, 2'b00, 2'b00, 2'b00, 6'b011100);
    tick();
    check_a("step halted", 2'b01, 2'b01, 2'b00, 2'b00, 6'b011100);
    step_a = 2'b00;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hart_run_ctl.md
HART_RUN_CTL -- requirements
Module: hart_run_ctl

Interface
REQ-001 SHALL have parameter NHARTS, default 1, meaning the number of independent hart channels (1..16).
REQ-002 SHALL have parameter HALT_TIMEOUT, default 255, meaning the maximum number of cycles in HALTING before the error flag is set (1..65535).
REQ-003 SHALL have parameter RESET_HALT, default 0, meaning that, when 1, every hart leaves reset in HALTING with cause 5.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port halt_req, input, NHARTS bits, level request from the debug module to halt hart i.
REQ-007 SHALL have port resume_req, input, NHARTS bits, level request to resume hart i.
REQ-008 SHALL have port core_halted, input, NHARTS bits, meaning the core of hart i has drained and parked.
REQ-009 SHALL have port core_retire, input, NHARTS bits, a one-cycle pulse per instruction retired by hart i.
REQ-010 SHALL have port step, input, NHARTS bits, the single-step enable (dcsr.step) of hart i.
REQ-011 SHALL have port debug, output, NHARTS bits, which drives the debug-mode entry of core i.
REQ-012 SHALL have port halted, output, NHARTS bits, meaning hart i is in HALTED.
REQ-013 SHALL have port resume_ack, output, NHARTS bits, a one-cycle pulse when hart i returns to RUNNING.
REQ-014 SHALL have port halt_cause, output, 3*NHARTS bits, the dcsr.cause of hart i in bits [3i+2:3i].
REQ-015 SHALL have port halt_err, output, NHARTS bits, a sticky flag set on HALTING timeout.
REQ-016 SHALL have ports any_halted and all_halted, output, 1 bit each, the OR and AND reductions of halted.

Function
REQ-017 SHALL implement one independent FSM per hart with states RUNNING, HALTING, HALTED and RESUMING; harts SHALL share no state.
REQ-018 In RUNNING, halt_req[i]=1 SHALL move the FSM to HALTING on the next edge and load cause 3.
REQ-019 In HALTING, core_halted[i]=1 SHALL move the FSM to HALTED on the next edge.
REQ-020 In HALTED, resume_req[i]=1 with halt_req[i]=0 SHALL move the FSM to RESUMING; if both requests are 1, halt SHALL win and the FSM SHALL stay HALTED.
REQ-021 In RESUMING, core_halted[i]=0 SHALL move the FSM to RUNNING and pulse resume_ack[i] for exactly one cycle, registered and coincident with the first RUNNING cycle.
REQ-022 halt_req and resume_req SHALL be ignored in HALTING and RESUMING; a halt_req still held on the first RUNNING cycle SHALL be honoured per REQ-018.
REQ-023 debug[i] SHALL be registered and equal 1 in HALTING and HALTED, and 0 in RUNNING and RESUMING.
REQ-024 halted[i] SHALL be registered and equal 1 only in HALTED; latency from halt_req to halted SHALL be 2 cycles when core_halted is already 1.
REQ-025 A per-hart counter, 16 bits wide and saturating, SHALL clear on HALTING entry and increment each HALTING cycle; when it reaches HALT_TIMEOUT, halt_err[i] SHALL set and the FSM SHALL remain in HALTING.
REQ-026 halt_err[i] SHALL clear only on reset or on a halt_req[i] rising edge seen in RUNNING.
REQ-027 halt_cause[i] SHALL hold its last loaded value in all states.

Reset
REQ-028 While rst=1, each FSM SHALL load RUNNING (or HALTING with cause 5 if RESET_HALT=1) on the same edge; all counters SHALL clear.
REQ-029 Reset values SHALL be: debug=0 (or all ones if RESET_HALT=1), halted=0, resume_ack=0, halt_err=0, halt_cause=0 (or 5 per hart if RESET_HALT=1).
REQ-030 Reset asserted mid-operation SHALL override every transition and pulse in the same cycle.

Configuration
REQ-031 Macro HART_RUN_CTL_STEP_EN SHALL compile in single-step.
REQ-032 With HART_RUN_CTL_STEP_EN defined, step[i] SHALL be sampled on the RESUMING-to-RUNNING transition. When it is 1, the first core_retire[i] pulse in RUNNING SHALL move the FSM to HALTING with cause 4. A simultaneous halt_req SHALL give cause 3.
REQ-033 Without HART_RUN_CTL_STEP_EN, step SHALL be unconnected internally and no step logic SHALL be synthesised.

Verification
REQ-034 NHARTS=2, core_halted tied to debug: pulse halt_req[0] -> debug[0]=1 after 1 cycle, halted[0]=1 after 2, halt_cause[0]=3, hart 1 unaffected.
REQ-035 Hart 0 HALTED, drive resume_req[0]=1 and halt_req[0]=1 together for 4 cycles -> halted[0] stays 1 and resume_ack[0] stays 0.
REQ-036 HALT_TIMEOUT=8, core_halted held 0, halt_req[1]=1 -> halt_err[1]=1 on the 8th HALTING cycle; the FSM stays HALTING until core_halted=1.
REQ-037 RESET_HALT=1: release rst -> all_halted=1 once core_halted=1, halt_cause=5 per hart; then resume_req -> exactly one resume_ack pulse per hart.
REQ-038 STEP_EN, step[0]=1: resume, then one core_retire pulse -> HALTING, cause 4, halted[0]=1 two cycles later.
REQ-039 Assert rst while hart 0 is in RESUMING -> the next cycle shows RUNNING with resume_ack=0 and all outputs at reset values.
